// File: rtl/dmem_responder_if.sv
// DMEM port bundle between core (master) and data-memory responder (slave).
// Ports: DIR_DMEM, DATA_WRITE_DMEM, READ, WRITE from core; DATA_READ_DMEM back.
interface dmem_responder_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] DIR_DMEM;
   logic [DATA_W-1:0] DATA_WRITE_DMEM;
   logic              READ;
   logic              WRITE;
   logic [DATA_W-1:0] DATA_READ_DMEM;

   modport master (
      output DIR_DMEM, DATA_WRITE_DMEM, READ, WRITE,
      input  DATA_READ_DMEM
   );

   modport slave (
      input  DIR_DMEM, DATA_WRITE_DMEM, READ, WRITE,
      output DATA_READ_DMEM
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus I/O window (LEDS, CYCLE, TX FIFO, STATUS).
// Ports: CLK, RESET_N, bus (DMEM slave), LEDS, TX_DATA/TX_VALID/TX_READY drain.
module dmem_responder #(
   parameter int                ADDR_W     = 10,
   parameter int                DATA_W     = 32,
   parameter logic [ADDR_W-1:0] IO_BASE    = 'h3F0,
   parameter int                FIFO_DEPTH = 4,
   parameter int                LED_W      = 8
) (
   input  logic                CLK,
   input  logic                RESET_N,
   dmem_responder_if.slave     bus,
   output logic [LED_W-1:0]    LEDS,
   output logic [7:0]          TX_DATA,
   output logic                TX_VALID,
   input  logic                TX_READY
);
   localparam int RAM_WORDS = int'(IO_BASE) / 4;
   localparam int PTR_W     = $clog2(FIFO_DEPTH);
   localparam int CNT_W     = PTR_W + 1;

   logic [DATA_W-1:0] ram [RAM_WORDS];
   logic [7:0]        fifo [FIFO_DEPTH];

   logic [31:0]      cycle;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             ovf;

   logic [ADDR_W-3:0] widx;
   logic [1:0]        off;
   logic              io_sel;
   logic              ram_sel, led_sel, cyc_sel, txd_sel, st_sel;
   logic              empty, full, pop, push_req, push_ok;
   logic              ovf_set, ovf_clr;
   logic              unused_addr;

   assign widx        = bus.DIR_DMEM[ADDR_W-1:2];
   assign off         = bus.DIR_DMEM[3:2];
   assign unused_addr = ^bus.DIR_DMEM[1:0];

   // The window is 16-byte aligned, so offset bits [3:2] pick the register.
   assign io_sel  = (bus.DIR_DMEM >= IO_BASE);
   assign ram_sel = !io_sel;
   assign led_sel = io_sel && (off == 2'd0);
   assign cyc_sel = io_sel && (off == 2'd1);
   assign txd_sel = io_sel && (off == 2'd2);
   assign st_sel  = io_sel && (off == 2'd3);

   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(FIFO_DEPTH));
   assign TX_VALID = !empty;
   assign TX_DATA  = TX_VALID ? fifo[rd_ptr] : 8'h00;

   assign pop      = TX_VALID && TX_READY;
   assign push_req = bus.WRITE && txd_sel;
   // A full FIFO still takes a push when the head leaves in the same edge.
   assign push_ok  = push_req && (!full || pop);
   assign ovf_set  = push_req && full && !pop;
   assign ovf_clr  = bus.WRITE && st_sel && bus.DATA_WRITE_DMEM[2];

   always_comb begin
      bus.DATA_READ_DMEM = '0;
      if (bus.READ) begin
         unique case (1'b1)
            ram_sel: bus.DATA_READ_DMEM = ram[widx];
            led_sel: bus.DATA_READ_DMEM = DATA_W'(LEDS);
            cyc_sel: bus.DATA_READ_DMEM = DATA_W'(cycle);
            txd_sel: bus.DATA_READ_DMEM = '0;
            st_sel:  bus.DATA_READ_DMEM =
                        DATA_W'({5'(count), ovf, full, empty});
            default: bus.DATA_READ_DMEM = '0;
         endcase
      end
   end

   // Storage arrays carry no reset.
   always_ff @(posedge CLK) begin
      if (bus.WRITE && ram_sel)
         ram[widx] <= bus.DATA_WRITE_DMEM;
      if (push_ok)
         fifo[wr_ptr] <= bus.DATA_WRITE_DMEM[7:0];
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         LEDS   <= '0;
         cycle  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (bus.WRITE && led_sel)
            LEDS <= bus.DATA_WRITE_DMEM[LED_W-1:0];
         // Software load beats the free-running increment.
         cycle <= (bus.WRITE && cyc_sel) ? '0 : cycle + 32'd1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (push_ok && !pop)
            count <= count + 1'b1;
         else if (pop && !push_ok)
            count <= count - 1'b1;
         // Set takes priority over a same-cycle clear.
         if (ovf_set)
            ovf <= 1'b1;
         else if (ovf_clr)
            ovf <= 1'b0;
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomised + directed bench for dmem_responder against a queue-based model.
// Drives the DMEM bus interface and TX_READY; checks loads, LEDS and TX side.
module tb_dmem_responder;
   logic       CLK;
   logic       RESET_N;
   logic [7:0] LEDS;
   logic [7:0] TX_DATA;
   logic       TX_VALID;
   logic       TX_READY;

   dmem_responder_if bus ();

   dmem_responder dut (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .bus      (bus),
      .LEDS     (LEDS),
      .TX_DATA  (TX_DATA),
      .TX_VALID (TX_VALID),
      .TX_READY (TX_READY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int          total = 0;
   int          bad = 0;
   logic [31:0] mram [int];
   logic [7:0]  q [$];
   logic [7:0]  outq [$];
   logic [7:0]  led;
   logic [31:0] cyc;
   logic        ovf;
   logic [31:0] last_rd;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      led = 8'h00;
      cyc = 32'h0;
      ovf = 1'b0;
      q.delete();
   endtask

   // One bus cycle: drive at posedge+1, check at negedge, model the edge.
   task automatic step(input logic [9:0] a, input logic [31:0] wd,
                       input logic r, input logic w, input logic rdy);
      logic        io;
      logic [1:0]  o;
      logic        known;
      logic [31:0] exp;
      logic [7:0]  b;
      bus.DIR_DMEM        = a;
      bus.DATA_WRITE_DMEM = wd;
      bus.READ            = r;
      bus.WRITE           = w;
      TX_READY            = rdy;
      io    = (a >= 10'h3F0);
      o     = a[3:2];
      known = 1'b1;
      exp   = 32'h0;
      @(negedge CLK);
      if (r) begin
         if (!io) begin
            if (mram.exists(int'(a >> 2))) exp = mram[int'(a >> 2)];
            else known = 1'b0;
         end else begin
            case (o)
               2'd0: exp = {24'h0, led};
               2'd1: exp = cyc;
               2'd2: exp = 32'h0;
               default: exp = {24'h0, 5'(q.size()), ovf,
                               q.size() == 4, q.size() == 0};
            endcase
         end
      end
      last_rd = bus.DATA_READ_DMEM;
      if (known) check("rd", last_rd, exp);
      check("leds", {24'h0, LEDS}, {24'h0, led});
      check("tx_valid", {31'h0, TX_VALID}, {31'h0, q.size() != 0});
      check("tx_data", {24'h0, TX_DATA},
            {24'h0, (q.size() != 0) ? q[0] : 8'h00});
      @(posedge CLK);
      #1;
      if (q.size() != 0 && rdy) begin
         b = q.pop_front();
         outq.push_back(b);
      end
      if (w && io && o == 2'd2) begin
         if (q.size() < 4) q.push_back(wd[7:0]);
         else ovf = 1'b1;
      end else if (w && io && o == 2'd3 && wd[2]) begin
         ovf = 1'b0;
      end
      cyc = (w && io && o == 2'd1) ? 32'h0 : cyc + 32'd1;
      if (w && io && o == 2'd0) led = wd[7:0];
      if (w && !io) mram[int'(a >> 2)] = wd;
   endtask

   task automatic mid_reset();
      #2 RESET_N = 1'b0;
      #1;
      check("rst_leds", {24'h0, LEDS}, 32'h0);
      check("rst_txv", {31'h0, TX_VALID}, 32'h0);
      check("rst_txd", {24'h0, TX_DATA}, 32'h0);
      @(posedge CLK);
      #1 RESET_N = 1'b1;
      model_reset();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

   initial begin
      logic [9:0]  a;
      logic [31:0] wd;
      RESET_N             = 1'b0;
      TX_READY            = 1'b0;
      bus.DIR_DMEM        = 10'h3F4;
      bus.DATA_WRITE_DMEM = 32'h0;
      bus.READ            = 1'b1;
      bus.WRITE           = 1'b0;
      model_reset();
      #2;
      check("reset_leds", {24'h0, LEDS}, 32'h0);
      check("reset_txv", {31'h0, TX_VALID}, 32'h0);
      check("reset_cycle_rd", bus.DATA_READ_DMEM, 32'h0);
      @(posedge CLK);
      @(posedge CLK);
      #1 RESET_N = 1'b1;

      step(10'h010, 32'hDEADBEEF, 0, 1, 0);
      step(10'h010, 32'h0, 1, 0, 0);
      check("ram_ld", last_rd, 32'hDEADBEEF);
      step(10'h013, 32'h0, 1, 0, 0);
      check("ram_ld_unal", last_rd, 32'hDEADBEEF);
      step(10'h010, 32'h0, 0, 0, 0);
      check("rd_low", last_rd, 32'h0);

      step(10'h3F0, 32'h1A5, 0, 1, 0);
      step(10'h3F0, 32'h0, 1, 0, 0);
      check("led_rd", last_rd, 32'hA5);
      check("led_pin", {24'h0, LEDS}, 32'hA5);
      step(10'h3F8, 32'h77, 0, 1, 0);
      mid_reset();
      step(10'h010, 32'h0, 1, 0, 0);
      check("ram_keep", last_rd, 32'hDEADBEEF);

      for (int i = 0; i < 9; i++) step(10'h000, 32'h0, 0, 0, 0);
      step(10'h3F4, 32'h0, 1, 0, 0);
      check("cyc10", last_rd, 32'd10);
      step(10'h3F4, 32'h0, 0, 1, 0);
      step(10'h3F4, 32'h0, 1, 0, 0);
      check("cyc_ld0", last_rd, 32'd0);
      step(10'h3F4, 32'h0, 1, 0, 0);
      check("cyc_ld1", last_rd, 32'd1);

      for (int i = 0; i < 4; i++) step(10'h3F8, 32'h41 + i, 0, 1, 0);
      step(10'h3FC, 32'h0, 1, 0, 0);
      check("st_full", last_rd, 32'h22);
      step(10'h3F8, 32'h45, 0, 1, 0);
      step(10'h3FC, 32'h0, 1, 0, 0);
      check("st_ovf", last_rd, 32'h26);
      outq.delete();
      for (int i = 0; i < 5; i++) step(10'h000, 32'h0, 0, 0, 1);
      check("drain_n", outq.size(), 4);
      for (int i = 0; i < 4; i++)
         check("drain_b", {24'h0, outq[i]}, 32'h41 + i);
      step(10'h3FC, 32'h0, 1, 0, 0);
      check("st_empty_ovf", last_rd, 32'h5);
      step(10'h3FC, 32'h4, 0, 1, 0);
      step(10'h3FC, 32'h0, 1, 0, 0);
      check("st_clr", last_rd, 32'h1);

      for (int i = 0; i < 4; i++) step(10'h3F8, 32'h1 + i, 0, 1, 0);
      outq.delete();
      step(10'h3F8, 32'h55, 0, 1, 1);
      for (int i = 0; i < 4; i++) step(10'h000, 32'h0, 0, 0, 1);
      check("fp_n", outq.size(), 5);
      check("fp_last", {24'h0, outq[outq.size() - 1]}, 32'h55);
      step(10'h3FC, 32'h0, 1, 0, 0);
      check("fp_st", last_rd, 32'h1);

      step(10'h020, 32'h11, 0, 1, 0);
      step(10'h020, 32'h22, 1, 1, 0);
      check("rw_old", last_rd, 32'h11);
      step(10'h020, 32'h0, 1, 0, 0);
      check("rw_new", last_rd, 32'h22);

      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 9) < 6) a = 10'($urandom_range(0, 255));
         else a = 10'h3F0 + 10'($urandom_range(0, 15));
         wd = $urandom;
         step(a, wd, 1'($urandom), 1'($urandom), 1'($urandom));
         if ($urandom_range(0, 149) == 0) mid_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target side of the core's DMEM port (DIR_DMEM, DATA_WRITE_DMEM, READ, WRITE, DATA_READ_DMEM).
- Contains a word-organised data RAM plus a small memory-mapped I/O window: LED register, free-running cycle counter, and a TX byte FIFO with status.
- Reads are combinational so the single-cycle core completes a load in the same cycle. Writes commit on the rising clock edge.
- The FIFO drain side feeds a future UART transmitter through a valid/ready handshake.

Parameters:
- ADDR_W, 10, byte-address width of DIR_DMEM.
- DATA_W, 32, data word width.
- IO_BASE, 10'h3F0, first byte address of the 16-byte I/O window (must be 16-byte aligned).
- FIFO_DEPTH, 4, TX FIFO entries (power of two, 2..16).
- LED_W, 8, LED register width.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- DIR_DMEM  in  ADDR_W  byte address from core.
- DATA_WRITE_DMEM  in  DATA_W  store data.
- READ  in  1  load strobe.
- WRITE  in  1  store strobe.
- DATA_READ_DMEM  out  DATA_W  load data, combinational.
- LEDS  out  LED_W  LED register contents.
- TX_DATA  out  8  FIFO head byte.
- TX_VALID  out  1  FIFO non-empty.
- TX_READY  in  1  consumer accepts head.

Behaviour:
- Address decode:
  - Word index = DIR_DMEM[ADDR_W-1:2]; DIR_DMEM[1:0] ignored (no byte lanes, no misalign trap).
  - Address >= IO_BASE selects I/O; below IO_BASE selects RAM. RAM depth = IO_BASE/4 words (252 at defaults).
- RAM:
  - Contents are not reset (undefined until written).
  - Write: on posedge when WRITE=1 and RAM is selected.
  - Read: combinational from the currently stored contents. A same-cycle READ and WRITE to the same word returns the old value.
- DATA_READ_DMEM = 0 whenever READ=0. READ and WRITE high together: both are performed as specified.
- I/O map (offsets from IO_BASE):
  - +0x0 LEDS, RW:
    - Write stores DATA_WRITE_DMEM[LED_W-1:0].
    - Read returns the value zero-extended.
    - Reset value 0.
  - +0x4 CYCLE, RW:
    - 32-bit counter, +1 every clock, wraps 0xFFFFFFFF -> 0.
    - A write loads 0, and load wins over increment: value is 0 on the following cycle, then 1, 2, ...
    - Read returns the current count. Reset value 0.
  - +0x8 TXDATA, WO:
    - Write pushes DATA_WRITE_DMEM[7:0].
    - Read returns 0.
  - +0xC STATUS:
    - Read: bit0 empty, bit1 full, bit2 overflow (sticky), bits[7:3] occupancy count; other bits 0.
    - Write with DATA_WRITE_DMEM[2]=1 clears overflow. Other bits are ignored.
- TX FIFO:
  - Circular buffer with read/write pointers and a count.
  - TX_VALID = (count != 0). TX_DATA = head entry, held stable while TX_VALID=1 and TX_READY=0.
  - Pop on posedge when TX_VALID && TX_READY.
  - Push accepted when count < FIFO_DEPTH, or when full and a pop occurs in the same cycle (count unchanged, pointers both advance).
  - Push while full without a pop: data dropped, overflow set to 1, count unchanged.
  - Simultaneous push and pop when non-empty and not full: count unchanged.
  - Push into an empty FIFO: TX_VALID rises on the next cycle, not combinationally.
  - Pointers wrap modulo FIFO_DEPTH.
  - Overflow set and clear in the same cycle: set wins.
- Reset (asynchronous, any time including mid-transfer):
  - LEDS=0, CYCLE=0, FIFO emptied (pointers and count 0), overflow=0.
  - TX_VALID=0 and TX_DATA=0 immediately.
  - DATA_READ_DMEM follows its combinational definition; RAM is untouched.
- Latency: loads 0 cycles; stores and all register effects visible the cycle after the write edge.

Test Plan:
- Store 0xDEADBEEF to 0x010, then load 0x010 and 0x013 -> both return 0xDEADBEEF. Load with READ=0 -> 0x00000000.
- Write 0x1A5 to 0x3F0 -> LEDS=0xA5, and a read of 0x3F0 returns 0x000000A5. Assert RESET_N low mid-cycle -> LEDS=0 immediately.
- Run 10 cycles after reset -> CYCLE read = 10. Write 0x3F4, then read next cycle -> 0, following cycle -> 1.
- With TX_READY=0, push 0x41,0x42,0x43,0x44,0x45 -> STATUS read 0x00000022 (count 4, full) then 0x00000026 (overflow). Raise TX_READY -> TX_DATA sequence 0x41..0x44, 0x45 never appears. STATUS then reads 0x00000005. Write 0x4 to STATUS -> reads 0x00000001.
- Fill FIFO to 4 entries, then push 0x55 in the same cycle as a pop -> accepted, overflow stays 0, and after draining the last byte out is 0x55.
- Same-cycle READ+WRITE to 0x020 (old 0x11, new 0x22) -> load returns 0x11 that cycle and 0x22 on the next read.
